// File: rtl/rc522_spi_responder.sv
// RC522-style SPI mode-0 register target: 64 x 8 register file reachable over an
// oversampled SPI slave and a local host port, with write/read event strobes.
module rc522_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  REG_INIT    = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [5:0] host_addr,
    input  logic       host_we,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       wr_valid,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_valid,
    output logic [5:0] rd_addr,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_s, cs_s, mosi_s;
    logic       sck_prev;
    logic       sck_rise, sck_fall;

    logic [2:0] bit_cnt_reg;
    logic [6:0] rx_shift_reg;
    logic [7:0] tx_shift_reg;
    logic [7:0] pending_reg;
    logic [5:0] addr_reg;
    logic [7:0] rx_byte;

    logic       active;
    logic       byte_done;
    logic       rd_fire;
    logic       wr_fire;
    logic       addr_wr_latch;

    logic [7:0]  regs [0:63];
    logic [63:0] spi_hit, host_hit;

    // cs idles high, so its synchronizer resets to 1 to keep busy low out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev  <= sck_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

    assign rx_byte  = {rx_shift_reg, mosi_s};
    assign active   = (state_reg != IDLE) && !cs_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rd_fire       = 1'b0;
        wr_fire       = 1'b0;
        addr_wr_latch = 1'b0;
        byte_done     = active && sck_rise && (bit_cnt_reg == 3'd7);
        case (state_reg)
            IDLE: begin
                if (!cs_s) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    if (rx_byte[7]) begin
                        state_next = RD;
                        rd_fire    = 1'b1;
                    end else begin
                        state_next    = WR;
                        addr_wr_latch = 1'b1;
                    end
                end
            end
            RD: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    rd_fire = 1'b1;
                end
            end
            WR: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    wr_fire = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift datapath is held cleared whenever no transfer is active, which also
    // discards any partial byte when cs rises and forces miso low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 7'd0;
            tx_shift_reg <= 8'h00;
            pending_reg  <= 8'h00;
            addr_reg     <= 6'd0;
        end else if (!active) begin
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 7'd0;
            tx_shift_reg <= 8'h00;
            pending_reg  <= 8'h00;
        end else begin
            if (sck_rise) begin
                rx_shift_reg <= rx_byte[6:0];
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            end
            if (sck_fall) begin
                if (bit_cnt_reg == 3'd0) begin
                    tx_shift_reg <= pending_reg;
                end else begin
                    tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                end
            end
            if (rd_fire) begin
                addr_reg    <= rx_byte[6:1];
                pending_reg <= regs[rx_byte[6:1]];
            end else if (addr_wr_latch) begin
                addr_reg    <= rx_byte[6:1];
                pending_reg <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_addr  <= 6'd0;
            wr_data  <= 8'h00;
            rd_valid <= 1'b0;
            rd_addr  <= 6'd0;
        end else begin
            wr_valid <= wr_fire;
            rd_valid <= rd_fire;
            if (wr_fire) begin
                wr_addr <= addr_reg;
                wr_data <= rx_byte;
            end
            if (rd_fire) begin
                rd_addr <= rx_byte[6:1];
            end
        end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_hit
        assign spi_hit[gi]  = wr_fire && (addr_reg == 6'(gi));
        assign host_hit[gi] = host_we && (host_addr == 6'(gi));
    end

    // SPI write takes priority over a same-cycle host write to the same entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                regs[i] <= REG_INIT;
            end
            host_rdata <= 8'h00;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (spi_hit[i]) begin
                    regs[i] <= rx_byte;
                end else if (host_hit[i]) begin
                    regs[i] <= host_wdata;
                end
            end
            host_rdata <= regs[host_addr];
        end
    end

    assign miso = tx_shift_reg[7];
    assign busy = ~cs_s;

endmodule

// File: tb/tb_rc522_spi_responder.sv
// Directed bench for rc522_spi_responder: a transaction-level model predicts MISO
// bytes, register contents and wr/rd event streams; a per-cycle monitor checks events.
`timescale 1ns/1ps
module tb_rc522_spi_responder;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [5:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [5:0] rd_addr;
    logic       busy;

    rc522_spi_responder #(
        .SYNC_STAGES(SYNC),
        .REG_INIT   (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .host_addr (host_addr),
        .host_we   (host_we),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    int rd_seen  = 0;

    logic [7:0]  model_regs [64];
    logic [13:0] wr_q [$];
    logic [5:0]  rd_q [$];
    logic [7:0]  miso_log [$];
    logic [13:0] exp_wr;
    logic [5:0]  exp_rd;
    logic [5:0]  coll_addr;
    logic [7:0]  coll_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event monitor: every strobe must match the next event the model predicted
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h, none expected", wr_addr, wr_data);
                end else begin
                    exp_wr = wr_q.pop_front();
                    check("wr_event", {18'd0, wr_addr, wr_data}, {18'd0, exp_wr});
                    $display("wr event addr=%0h data=%0h", wr_addr, wr_data);
                end
            end
            if (rd_valid) begin
                rd_seen++;
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got addr %0h, none expected", rd_addr);
                end else begin
                    exp_rd = rd_q.pop_front();
                    check("rd_event", {26'd0, rd_addr}, {26'd0, exp_rd});
                    $display("rd event addr=%0h", rd_addr);
                end
            end
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit collide,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            mosi = tx[i];
            repeat (HALF - 1) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (collide && i == 0) begin
                    if (c == SYNC) begin
                        host_addr  = coll_addr;
                        host_wdata = coll_data;
                        host_we    = 1'b1;
                    end else if (c == SYNC + 1) begin
                        host_we = 1'b0;
                    end
                end
            end
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_high", busy, 1'b1);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_low", busy, 1'b0);
        check("miso_idle", miso, 1'b0);
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic host_check(input logic [5:0] a, input string name);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        check(name, host_rdata, model_regs[a]);
        $display("host read addr=%0h data=%0h", a, host_rdata);
    endtask

    // One SPI transaction of n full bytes, optionally ended by a partial byte.
    task automatic spi_transfer(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input int partial_bits, input logic [7:0] partial_byte,
                                input bit collide);
        logic [7:0] b [4];
        logic [7:0] rx;
        logic [7:0] exp_m;
        logic       is_rd;
        logic [5:0] a;
        logic [5:0] prev_a;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        miso_log.delete();
        cs_low();
        is_rd  = b[0][7];
        a      = b[0][6:1];
        prev_a = a;
        for (int k = 0; k < n; k++) begin
            exp_m = 8'h00;
            if (k == 0) begin
                if (is_rd) rd_q.push_back(a);
            end else if (is_rd) begin
                exp_m  = model_regs[prev_a];
                prev_a = b[k][6:1];
                rd_q.push_back(prev_a);
            end else begin
                model_regs[a] = b[k];
                wr_q.push_back({a, b[k]});
            end
            spi_bits(b[k], 8, collide && (k == n - 1), rx);
            miso_log.push_back(rx);
            check($sformatf("miso_byte%0d", k), rx, exp_m);
        end
        if (partial_bits > 0) spi_bits(partial_byte, partial_bits, 1'b0, rx);
        cs_high();
        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("spi transfer n=%0d first=%0h partial_bits=%0d", n, b0, partial_bits);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        host_addr = 6'd0; host_we = 1'b0; host_wdata = 8'h00;
        coll_addr = 6'd0; coll_data = 8'h00;
        for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_host_rdata", host_rdata, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1. single write
        spi_transfer(2, 8'h02, 8'h0F, 8'h00, 8'h00, 0, 8'h00, 1'b0);
        host_check(6'd1, "t1_reg1");
        check("t1_reg1_lit", host_rdata, 8'h0F);
        check("t1_wr_count", wr_seen, 1);

        // 2. read after host write
        host_write(6'h37, 8'h92);
        spi_transfer(2, 8'hEE, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0);
        check("t2_miso_lit", miso_log[1], 8'h92);
        check("t2_rd_count", rd_seen, 2);

        // 3. burst write to one register
        spi_transfer(4, 8'h12, 8'hA1, 8'hB2, 8'hC3, 0, 8'h00, 1'b0);
        check("t3_wr_count", wr_seen, 4);
        host_check(6'd9, "t3_reg9");
        check("t3_reg9_lit", host_rdata, 8'hC3);

        // chained read of regs 1 and 9
        spi_transfer(3, 8'h82, 8'h92, 8'h00, 8'h00, 0, 8'h00, 1'b0);
        check("t3r_miso1_lit", miso_log[1], 8'h0F);
        check("t3r_miso2_lit", miso_log[2], 8'hC3);

        // 4. abort after 5 bits of a data byte, then a clean transfer
        spi_transfer(1, 8'h12, 8'h00, 8'h00, 8'h00, 5, 8'h5A, 1'b0);
        check("t4_wr_count", wr_seen, 4);
        host_check(6'd9, "t4_reg9");
        check("t4_reg9_lit", host_rdata, 8'hC3);
        spi_transfer(2, 8'h14, 8'h3C, 8'h00, 8'h00, 0, 8'h00, 1'b0);
        host_check(6'd10, "t4_reg10");
        check("t4_reg10_lit", host_rdata, 8'h3C);

        // 5. same-cycle host and SPI write to reg 9: SPI wins
        coll_addr = 6'd9;
        coll_data = 8'hAA;
        spi_transfer(2, 8'h12, 8'h55, 8'h00, 8'h00, 0, 8'h00, 1'b1);
        host_check(6'd9, "t5_reg9");
        check("t5_reg9_lit", host_rdata, 8'h55);

        // 6. reset during the data byte of a read
        cs_low();
        rd_q.push_back(6'h37);
        spi_bits(8'hEE, 8, 1'b0, rx);
        check("t6_miso_addr_byte", rx, 8'h00);
        spi_bits(8'h00, 3, 1'b0, rx);
        host_addr = 6'h37;
        repeat (4) @(negedge clk);
        check("t6_pre_miso", miso, model_regs[6'h37][4]);
        check("t6_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_miso", miso, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_host_rdata", host_rdata, 8'h00);
        check("t6_wr_addr", wr_addr, 6'd0);
        check("t6_wr_data", wr_data, 8'h00);
        check("t6_rd_addr", rd_addr, 6'd0);
        cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        rd_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("t6_idle_busy", busy, 1'b0);
        host_check(6'h37, "t6_reg37");
        host_check(6'd9, "t6_reg9");
        spi_transfer(2, 8'h02, 8'h77, 8'h00, 8'h00, 0, 8'h00, 1'b0);
        spi_transfer(2, 8'h82, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0);
        check("t6_post_lit", miso_log[1], 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
